// File: rtl/ats21_pkg.sv
// Shared types for the ATS21 host port.
// This covers the opcode set, the instruction layout and the host FSM states.
package ats21_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_SET_CLK = 3'b001,
    OP_EN_CLK  = 3'b010,
    OP_MODE    = 3'b011,
    OP_SET_ALM = 3'b101,
    OP_SET_TMR = 3'b110,
    OP_EN_ALM  = 3'b111
  } opcode_e;

  // The opcode is kept as raw bits so that unlisted opcodes pass through untouched.
  typedef struct packed {
    logic [2:0]  opcode;
    logic [4:0]  id;
    logic [7:0]  flags;
    logic [15:0] value;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4
  } host_state_e;

  function automatic logic is_nop(instr_t instr);
    return instr.opcode == OP_NOP;
  endfunction

endpackage

// File: rtl/ats21_host_port_if.sv
// Local instruction queue and completion channel of one ATS21 host port.
// cmd: the word transfers at a clock edge where cmd_valid and cmd_ready are both high;
// the master holds cmd_data stable while cmd_valid is high; rsp_* is a one-cycle pulse with no backpressure.
interface ats21_host_port_if;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic        rsp_ack;
  logic [2:0]  rsp_retries;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, rsp_valid, rsp_ack, rsp_retries
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, rsp_valid, rsp_ack, rsp_retries
  );
endinterface

// File: rtl/ats21_alarm_capture.sv
// Turns the short ATS21 alarm "finished" pulses into sticky, write-one-to-clear pending bits.
// It also produces a registered interrupt.
module ats21_alarm_capture #(
  parameter int NUM_ALARMS = 24
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_ALARMS-1:0] i_data_in,
  input  logic [NUM_ALARMS-1:0] i_alarm_clr,
  output logic [NUM_ALARMS-1:0] o_alarm_pend,
  output logic                  o_alarm_irq
);

  logic [NUM_ALARMS-1:0] r_data_q;
  logic [NUM_ALARMS-1:0] r_pend;
  logic                  r_irq;
  logic [NUM_ALARMS-1:0] w_rise;
  logic [NUM_ALARMS-1:0] w_pend_next;

  // A rise beats a coincident clear, and only the rising edge of a held level counts.
  assign w_rise      = i_data_in & ~r_data_q;
  assign w_pend_next = (r_pend & ~i_alarm_clr) | w_rise;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data_q <= '0;
      r_pend   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_data_q <= i_data_in;
      r_pend   <= w_pend_next;
      r_irq    <= |w_pend_next;
    end
  end

  assign o_alarm_pend = r_pend;
  assign o_alarm_irq  = r_irq;

endmodule

// File: rtl/ats21_host_port.sv
// ATS21 client-side initiator.
// Each 32-bit instruction goes out as a high beat then a low beat, with Ack/Nack retry, plus alarm capture.
module ats21_host_port
  import ats21_pkg::*;
#(
  parameter int RSP_LAT    = 1,
  parameter int MAX_RETRY  = 2,
  parameter int NUM_ALARMS = 24
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  ats21_host_port_if.slave      host,
  output logic                  o_req,
  output logic [15:0]           o_ctrl,
  input  logic                  i_stat_in,
  input  logic [NUM_ALARMS-1:0] i_data_in,
  input  logic [NUM_ALARMS-1:0] i_alarm_clr,
  output logic [NUM_ALARMS-1:0] o_alarm_pend,
  output logic                  o_alarm_irq,
  output host_state_e           o_state
);

  localparam logic [2:0] LAT_CNT = 3'(RSP_LAT);
  localparam logic [2:0] MAX_CNT = 3'(MAX_RETRY);

  host_state_e r_state;
  instr_t      r_instr;
  logic [2:0]  r_cnt;
  logic [2:0]  r_retry;
  logic        r_reissue;
  logic        r_req;
  logic [15:0] r_ctrl;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic        r_rsp_ack;
  logic [2:0]  r_rsp_retries;
  instr_t      w_cmd;

  assign w_cmd = instr_t'(host.cmd_data);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_instr       <= '0;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_reissue     <= 1'b0;
      r_req         <= 1'b0;
      r_ctrl        <= '0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_ack     <= 1'b0;
      r_rsp_retries <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (host.cmd_valid && r_cmd_ready) begin
            r_retry <= '0;
            if (is_nop(w_cmd)) begin
              r_rsp_valid   <= 1'b1;
              r_rsp_ack     <= 1'b1;
              r_rsp_retries <= '0;
            end else begin
              r_instr     <= w_cmd;
              r_cmd_ready <= 1'b0;
              r_req       <= 1'b1;
              r_ctrl      <= {w_cmd.opcode, w_cmd.id, w_cmd.flags};
              r_state     <= S_HI;
            end
          end
        end
        S_HI: begin
          r_ctrl  <= r_instr.value;
          r_state <= S_LO;
        end
        S_LO: begin
          r_req   <= 1'b0;
          r_ctrl  <= '0;
          r_cnt   <= LAT_CNT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          // The count reaches zero on this edge, so this is the stat sampling point.
          if (r_cnt == 3'd1) begin
            r_state   <= S_GAP;
            r_reissue <= 1'b0;
            if (i_stat_in) begin
              r_rsp_valid   <= 1'b1;
              r_rsp_ack     <= 1'b1;
              r_rsp_retries <= r_retry;
            end else if (r_retry < MAX_CNT) begin
              r_retry   <= r_retry + 3'd1;
              r_reissue <= 1'b1;
            end else begin
              r_rsp_valid   <= 1'b1;
              r_rsp_ack     <= 1'b0;
              r_rsp_retries <= r_retry;
            end
          end
        end
        S_GAP: begin
          if (r_reissue) begin
            r_req   <= 1'b1;
            r_ctrl  <= {r_instr.opcode, r_instr.id, r_instr.flags};
            r_state <= S_HI;
          end else begin
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_req       <= 1'b0;
          r_ctrl      <= '0;
          r_cmd_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  ats21_alarm_capture #(
    .NUM_ALARMS(NUM_ALARMS)
  ) u_alarm (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_data_in   (i_data_in),
    .i_alarm_clr (i_alarm_clr),
    .o_alarm_pend(o_alarm_pend),
    .o_alarm_irq (o_alarm_irq)
  );

  assign host.cmd_ready   = r_cmd_ready;
  assign host.rsp_valid   = r_rsp_valid;
  assign host.rsp_ack     = r_rsp_ack;
  assign host.rsp_retries = r_rsp_retries;
  assign o_req            = r_req;
  assign o_ctrl           = r_ctrl;
  assign o_state          = r_state;

endmodule
